// File: rtl/mux_rr_arb_nch.sv
// M-channel, N-bit registered mux with a round-robin arbiter and valid/ready on both sides.
// Optional transfer counter port xfer_cnt when MUX_RR_STATS_EN is defined.
module mux_rr_arb_nch #(
    parameter  int N  = 8,
    parameter  int M  = 8,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
`ifdef MUX_RR_STATS_EN
    ,
    output logic [15:0]    xfer_cnt
`endif
);

    logic [SW-1:0] r_ptr;
    logic [N-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic          r_out_valid;

    logic          w_load_en;
    logic          w_found;
    logic          w_xfer;
    logic [SW-1:0] w_gnt;
    logic [SW-1:0] w_ptr_nxt;
    logic [M-1:0]  w_onehot;
    logic [N-1:0]  w_data;
    int            w_j;

    // in_ready is also held low while reset is asserted, so no handshake can complete then.
    assign w_load_en = (!r_out_valid || out_ready) && !rst;
    assign w_xfer    = w_load_en && w_found;
    assign in_ready  = w_xfer ? w_onehot : '0;

    // Rotating priority search starting at r_ptr; wrap is done against M, not a power of 2.
    always_comb begin
        w_found   = 1'b0;
        w_gnt     = '0;
        w_ptr_nxt = '0;
        w_onehot  = '0;
        w_data    = '0;
        w_j       = 0;
        for (int k = 0; k < M; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= M) w_j = w_j - M;
            if (!w_found && in_valid[w_j]) begin
                w_found      = 1'b1;
                w_gnt        = SW'(w_j);
                w_onehot[w_j] = 1'b1;
                w_data       = in_data[w_j*N +: N];
                w_ptr_nxt    = (w_j == M-1) ? '0 : SW'(w_j + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_ptr       <= w_ptr_nxt;
            r_out_data  <= w_data;
            r_out_sel   <= w_gnt;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

`ifdef MUX_RR_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_xfer_cnt <= '0;
        else if (r_out_valid && out_ready)
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
